// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared definitions for the rv32i core.
//   XLEN          - data/PC width
//   NOP_INSTR     - canonical NOP (addi x0, x0, 0)
//   fetch_state_t - fetch stage control states
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: one-entry valid/ready pipeline register with flush.
//   clk, rst (async, active-low)
//   in_valid/in_data/in_ready : upstream side; a load happens on in_valid && in_ready
//   flush/flush_data          : drops the held entry and overwrites data; beats a load
//   out_valid/out_ready/out_data : downstream side
// The entry is replaced whenever it is empty or being consumed in the same cycle,
// so a full stream moves one entry per cycle.
module fetch_out_reg #(
  parameter int            W          = 64,
  parameter logic [W-1:0]  RESET_DATA = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         flush,
  input  logic [W-1:0] flush_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= RESET_DATA;
    end else if (flush) begin
      valid_q <= 1'b0;
      data_q  <= flush_data;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: rv32i fetch stage in front of a combinational instruction Rom.
//   clk, rst (async, active-low)
//   rom_addr  : word address to the Rom, taken straight from pc
//   rom_data  : Rom word for rom_addr, same cycle
//   redirect_valid/redirect_pc : branch/jump target from execute
//   out_valid/out_ready/out_instr/out_pc : fetched word towards decode
//   fault     : sticky, set by a redirect to a non word-aligned target
module instr_fetch #(
  parameter int                XLEN      = rv32i_pkg::XLEN,
  parameter int                ROM_DEPTH = 64,
  parameter logic [XLEN-1:0]   RESET_PC  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [$clog2(ROM_DEPTH)-1:0]  rom_addr,
  input  logic [XLEN-1:0]               rom_data,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_instr,
  output logic [XLEN-1:0]               out_pc,
  output logic                          fault
);

  import rv32i_pkg::*;

  localparam int ADDR_W = $clog2(ROM_DEPTH);

  fetch_state_t      state, state_next;
  logic [XLEN-1:0]   pc, pc_next;
  logic              fault_next;
  logic              fetch_valid;
  logic              fetch_ready;
  logic              flush;
  logic [2*XLEN-1:0] out_data;

  // Rom aliases every ROM_DEPTH words; upper pc bits only show up in out_pc.
  assign rom_addr = pc[ADDR_W+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      fault <= fault_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    fault_next  = fault;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    unique case (state)
      BOOT: state_next = RUN;
      RUN: begin
        // A redirect always flushes; a word being handed to decode in this
        // same cycle still leaves, decode is responsible for squashing it.
        if (redirect_valid) begin
          flush = 1'b1;
          if (redirect_pc[1:0] == 2'b00) begin
            pc_next = redirect_pc;
          end else begin
            state_next = FAULT;
            fault_next = 1'b1;
          end
        end else begin
          fetch_valid = 1'b1;
          if (fetch_ready) pc_next = pc + XLEN'(4);
        end
      end
      FAULT: ;
      default: state_next = BOOT;
    endcase
  end

  fetch_out_reg #(
    .W          (2 * XLEN),
    .RESET_DATA ({XLEN'(NOP_INSTR), XLEN'(0)})
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (fetch_valid),
    .in_data    ({rom_data, pc}),
    .in_ready   (fetch_ready),
    .flush      (flush),
    .flush_data ({XLEN'(NOP_INSTR), out_pc}),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  assign out_instr = out_data[2*XLEN-1:XLEN];
  assign out_pc    = out_data[XLEN-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  logic [31:0] rom_mem [DEPTH];

  always #5 clk = ~clk;

  initial for (int i = 0; i < DEPTH; i++) rom_mem[i] = 32'h1000_0000 + i;
  assign rom_data = rom_mem[rom_addr];

  instr_fetch #(.XLEN(32), .ROM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: what fetch must present, from the stage's rules.
  // mode: 0 = first cycle after reset, 1 = fetching, 2 = faulted.
  int unsigned m_mode;
  logic [31:0] m_next_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_fault;

  function automatic logic [31:0] rom_word(input logic [31:0] byte_addr);
    return 32'h1000_0000 + ((byte_addr >> 2) % DEPTH);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_next_pc = 32'h0; m_valid = 1'b0;
      m_instr = 32'h0000_0013; m_pc = 32'h0; m_fault = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (redirect_valid) begin
        m_valid = 1'b0;
        if (redirect_pc % 4 == 0) begin
          m_next_pc = redirect_pc;
          m_instr   = 32'h0000_0013;
        end else begin
          m_mode  = 2;
          m_fault = 1'b1;
        end
      end else if (!m_valid || out_ready) begin
        m_instr   = rom_word(m_next_pc);
        m_pc      = m_next_pc;
        m_valid   = 1'b1;
        m_next_pc = m_next_pc + 32'd4;
      end
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("cyc_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("cyc_fault", {31'b0, fault}, {31'b0, m_fault});
      chk("cyc_rom_addr", {26'b0, rom_addr}, (m_next_pc >> 2) % DEPTH);
      if (m_valid) begin
        chk("cyc_pc", out_pc, m_pc);
        chk("cyc_instr", out_instr, m_instr);
      end else if (m_mode != 2) begin
        chk("cyc_instr_idle", out_instr, m_instr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    // Test 1: reset release
    step();
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_instr", out_instr, 32'h0000_0013);
    chk("reset_fault", {31'b0, fault}, 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    chk("boot_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("first_valid", {31'b0, out_valid}, 32'd1);
    chk("first_pc", out_pc, 32'h0);
    chk("first_instr", out_instr, 32'h1000_0000);
    step();
    chk("second_pc", out_pc, 32'h4);
    chk("second_instr", out_instr, 32'h1000_0001);
    step();
    chk("third_pc", out_pc, 32'h8);
    chk("third_instr", out_instr, 32'h1000_0002);

    // Test 2: stall
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", out_pc, 32'h8);
      chk("stall_instr", out_instr, 32'h1000_0002);
      chk("stall_rom_addr", {26'b0, rom_addr}, 32'd3);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("post_stall_pc", out_pc, 32'hC);
    chk("post_stall_instr", out_instr, 32'h1000_0003);

    // Test 3: redirect while stalled
    out_ready = 1'b0;
    step();
    redirect(32'h40);
    chk("redir_flush_valid", {31'b0, out_valid}, 32'd0);
    chk("redir_flush_instr", out_instr, 32'h0000_0013);
    step();
    chk("redir_valid", {31'b0, out_valid}, 32'd1);
    chk("redir_pc", out_pc, 32'h40);
    chk("redir_instr", out_instr, 32'h1000_0010);
    out_ready = 1'b1;

    // Test 4: wrap/alias
    redirect(32'hFC);
    chk("alias_rom_addr0", {26'b0, rom_addr}, 32'd63);
    step();
    chk("alias_pc_fc", out_pc, 32'hFC);
    chk("alias_instr_fc", out_instr, 32'h1000_003F);
    chk("alias_rom_addr", {26'b0, rom_addr}, 32'd0);
    step();
    chk("alias_pc_100", out_pc, 32'h100);
    chk("alias_instr_100", out_instr, 32'h1000_0000);

    // Test 5: misaligned redirect
    redirect(32'h42);
    chk("mis_fault", {31'b0, fault}, 32'd1);
    chk("mis_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mis_hold_fault", {31'b0, fault}, 32'd1);
      chk("mis_hold_valid", {31'b0, out_valid}, 32'd0);
    end
    redirect(32'h0);
    step();
    chk("mis_ignore_fault", {31'b0, fault}, 32'd1);
    chk("mis_ignore_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mis_reset_fault", {31'b0, fault}, 32'd0);
    step();
    rst = 1'b1;
    step();
    step();
    chk("restart_valid", {31'b0, out_valid}, 32'd1);
    chk("restart_pc", out_pc, 32'h0);
    chk("restart_instr", out_instr, 32'h1000_0000);

    // Randomized traffic, aligned redirects only (incl. top-of-space targets)
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(15) == 0);
      case ($urandom_range(3))
        0:       redirect_pc = 32'hFFFF_FFF0 | ($urandom_range(3) << 2);
        default: redirect_pc = ($urandom & 32'h0000_03FC);
      endcase
      step();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    // Test 6: async reset mid-stream
    chk("pre_async_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_valid", {31'b0, out_valid}, 32'd0);
    chk("async_instr", out_instr, 32'h0000_0013);
    chk("async_pc", out_pc, 32'h0);
    chk("async_fault", {31'b0, fault}, 32'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      out_ready = ($urandom_range(1) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the rv32i core. Sits directly upstream of the combinational instruction Rom.
- Owns the PC and drives the Rom word address. Captures the returned word into a one-entry output register.
- Presents the captured word to decode over a valid/ready handshake.
- Accepts branch/jump redirects, which flush the output register.

Parameters:
- XLEN, 32, data and PC width.
- ROM_DEPTH, 64, Rom depth in words; must match the Rom MEM_DEPTH.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, $clog2(ROM_DEPTH), derived localparam, Rom address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- rom_addr  out  ADDR_W  word address to Rom; combinational = pc[ADDR_W+1:2].
- rom_data  in  XLEN  Rom dout; combinational response to rom_addr in the same cycle.
- redirect_valid  in  1  redirect request from execute.
- redirect_pc  in  XLEN  redirect target byte address.
- out_valid  out  1  out_instr/out_pc hold a valid fetched instruction.
- out_ready  in  1  decode accepts the word this cycle.
- out_instr  out  XLEN  fetched instruction.
- out_pc  out  XLEN  byte address of out_instr.
- fault  out  1  sticky misaligned-redirect fault.

Behaviour:
- Reset (rst low, async, takes effect immediately):
  - pc=RESET_PC, state=BOOT, out_valid=0, out_instr=NOP (32'h0000_0013), out_pc=0, fault=0.
- States: BOOT, RUN, FAULT.
- BOOT: lasts exactly one cycle after rst deasserts. No output load. Always goes to RUN.
- RUN, load condition L = !out_valid || out_ready:
  - If L: out_instr<=rom_data, out_pc<=pc, out_valid<=1, pc<=pc+4.
  - If !L (stall): pc, out_* all hold; rom_addr stays stable.
- Handshake:
  - A transfer occurs on a cycle with out_valid && out_ready.
  - While stalled, out_valid, out_instr and out_pc must not change, except on redirect.
- Redirect (RUN only) has priority over the load/stall logic and is taken regardless of out_ready.
  - redirect_pc[1:0]==0: pc<=redirect_pc, out_valid<=0, out_instr<=NOP.
  - redirect_pc[1:0]!=0: state<=FAULT, fault<=1, out_valid<=0; pc is not updated.
- FAULT:
  - out_valid stays 0, fault stays 1, pc frozen, redirects ignored.
  - Left only via reset.
- Latency:
  - First out_valid is seen in the 2nd cycle after rst deassertion (BOOT cycle, then load edge).
  - Redirect asserted in cycle N gives out_valid=1 with out_pc=target in cycle N+2. Penalty is 2 cycles; the word present during N is discarded.
- Steady state with out_ready=1: one instruction per cycle, PCs incrementing by 4.
- Arithmetic and wrap:
  - pc+4 is modulo 2^XLEN.
  - rom_addr uses only pc[ADDR_W+1:2], so the Rom aliases every ROM_DEPTH*4 bytes.
  - out_pc always reports the full 32-bit pc. No range fault.
- Simultaneous events:
  - redirect_valid with out_valid && out_ready: the current word is still transferred to decode this cycle (decode owns squash); the fetch side then flushes as above.
  - redirect_valid in BOOT is ignored.
- Outputs are driven only by registers, except rom_addr.

Decomposition:
- rv32i_pkg holds:
  - XLEN;
  - NOP_INSTR = 32'h0000_0013;
  - fetch_state_t enum {BOOT, RUN, FAULT}.
- One sub-module: fetch_out_reg, the valid/ready one-entry output register with flush input. It is reused later for other inter-stage registers.
- The PC and FSM live in instr_fetch.

Test Plan:
- Rom preloaded with word i = 32'h1000_0000+i.
- Test 1, reset release: rst 0→1, out_ready=1 → out_valid rises in 2nd cycle; (out_pc,out_instr) = (0,0x10000000), (4,0x10000001), (8,0x10000002) on consecutive cycles.
- Test 2, stall: out_ready=0 for 3 cycles while out_pc=8 → out_pc/out_instr/rom_addr=3 stable. After release, next word is out_pc=0xC, instr 0x10000003.
- Test 3, redirect while stalled: redirect to 0x40 during stall → out_valid=0 next cycle; one cycle later out_pc=0x40, out_instr=0x10000010.
- Test 4, wrap/alias: redirect to 0xFC → out_pc=0xFC instr 0x1000003F, then out_pc=0x100, rom_addr=0, instr 0x10000000.
- Test 5, misaligned redirect: redirect to 0x42 → fault=1, out_valid=0 held for 10 cycles. A following redirect to 0x0 is ignored. Reset clears fault and restarts at 0.
- Test 6, async reset mid-stream: drop rst between clock edges → out_valid=0, out_instr=0x00000013, out_pc=0, fault=0 before the next clk edge.
